// File: rtl/time_display_pkg.sv
// Shared constants for the hh:mm:ss display: segment patterns, digit count and setup-field codes.
package time_display_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment order {g,f,e,d,c,b,a}, active-low (common-anode).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } setup_e;

endpackage

// File: rtl/time_display_bin2bcd.sv
// bin2bcd_99: combinational 8-bit binary to tens/ones for 0..99; ovf_o flags values above 99.
module bin2bcd_99 (
  input  logic [7:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       ovf_o
);
  logic [7:0] tens_full;
  logic [7:0] ones_full;

  always_comb begin
    tens_full = bin_i / 8'd10;
    ones_full = bin_i % 8'd10;
    ovf_o     = (bin_i > 8'd99);
    tens_o    = 4'd0;
    ones_o    = 4'd0;
    if (!ovf_o) begin
      tens_o = tens_full[3:0];
      ones_o = ones_full[3:0];
    end
  end
endmodule

// File: rtl/time_display.sv
// time_display: 6-digit multiplexed 7-segment driver for a packed hh:mm:ss word with setup/alarm blink.
// Optional: define LEADING_ZERO_BLANK_EN to suppress a zero on the hours-tens digit.
module time_display
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [23:0]           data,
  input  logic [1:0]            setup_rezhim,
  input  logic                  alarm,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]         DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [2:0]            digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [23:0]           snap_q, snap_d;
  logic [1:0]            setup_prev_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0] tens [3];
  logic [3:0] ones [3];
  logic       ovf  [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_conv
    bin2bcd_99 u_conv (
      .bin_i  (snap_q[gi*8 +: 8]),
      .tens_o (tens[gi]),
      .ones_o (ones[gi]),
      .ovf_o  (ovf[gi])
    );
  end

  logic       scan_wrap, setup_chg, phase_eff, lz_blank, blank;
  logic [1:0] field, sel_field;
  logic [3:0] bcd;

  always_comb begin
    scan_wrap = (scan_cnt_q == SCAN_MAX);
    setup_chg = (setup_rezhim != setup_prev_q);
    // A field change must show the new field at once, so the stale phase is masked this cycle.
    phase_eff = blink_phase_q & ~setup_chg;
    field     = digit_idx_q[2:1];
    sel_field = setup_rezhim - SET_SEC;

    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_wrap)
      digit_idx_d = (digit_idx_q == DIGIT_LAST) ? 3'd0 : digit_idx_q + 3'd1;
    snap_d = (scan_wrap && digit_idx_q == DIGIT_LAST) ? data : snap_q;

    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (setup_chg) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (digit_idx_q == DIGIT_LAST) && !ovf[2] && (tens[2] == 4'd0);
`else
    lz_blank = 1'b0;
`endif

    blank = (alarm && phase_eff)
         || (setup_rezhim != RUN && field == sel_field && phase_eff)
         || lz_blank;

    bcd  = digit_idx_q[0] ? tens[field] : ones[field];
    an_d = ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d = ovf[field] ? SEG_DASH : SEG_DIGIT[bcd];
    dp_d  = !(digit_idx_q == 3'd2 || digit_idx_q == 3'd4);
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= 24'd0;
      setup_prev_q  <= 2'd0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      setup_prev_q  <= setup_rezhim;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
